// File: rtl/fifo_port_pkg.sv
// Shared types and sizes for the FIFO port controller and its arbiter.
package fifo_port_pkg;

    localparam int DW     = 8;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;
    localparam int MEM_AW = 4;

    typedef enum logic {PRIO_WR, PRIO_RD} prio_t;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

endpackage

// File: rtl/fifo_port_arb.sv
// One-grant-per-cycle arbiter between FIFO writes and refill reads.
// Priority only flips when both sides ask, so an idle side never loses its turn.
module fifo_port_arb
    import fifo_port_pkg::*;
(
    input  logic  want_wr,
    input  logic  want_rd,
    input  prio_t prio,
    output logic  gnt_wr,
    output logic  gnt_rd,
    output prio_t prio_next
);

    always_comb begin
        gnt_wr    = 1'b0;
        gnt_rd    = 1'b0;
        prio_next = prio;
        if (want_wr && want_rd) begin
            if (prio == PRIO_WR) begin
                gnt_wr    = 1'b1;
                prio_next = PRIO_RD;
            end else begin
                gnt_rd    = 1'b1;
                prio_next = PRIO_WR;
            end
        end else begin
            gnt_wr = want_wr;
            gnt_rd = want_rd;
        end
    end

endmodule

// File: rtl/fifo_port_ctrl.sv
// Ready/valid FIFO front end for the 8x8 single-port register file, with a registered output stage.
// Optional high-water mark tracking is enabled by defining FIFO_PORT_CTRL_HWM_EN.
module fifo_port_ctrl
    import fifo_port_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef FIFO_PORT_CTRL_HWM_EN
    input  logic              hwm_clr,
    output logic [AW:0]       hwm,
`endif
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DW-1:0]     push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DW-1:0]     pop_data,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    prio_t prio;
    prio_t prio_next;
    cnt_t  count_next;
    logic  want_wr;
    logic  want_rd;
    logic  gnt_wr;
    logic  gnt_rd;

    assign full      = (count == cnt_t'(DEPTH));
    assign empty     = (count == '0);
    assign mem_wdata = push_data;

    // A refill is allowed whenever the out register is free or is being drained this cycle.
    always_comb begin
        want_wr = push_valid && !full;
        want_rd = !empty && (!pop_valid || pop_ready);
    end

    fifo_port_arb u_arb (
        .want_wr   (want_wr),
        .want_rd   (want_rd),
        .prio      (prio),
        .gnt_wr    (gnt_wr),
        .gnt_rd    (gnt_rd),
        .prio_next (prio_next)
    );

    // Idle cycles park the address on rd_ptr.
    always_comb begin
        push_ready = gnt_wr;
        mem_wen    = gnt_wr;
        mem_ren    = gnt_rd;
        mem_addr   = {{(MEM_AW-AW){1'b0}}, (gnt_wr ? wr_ptr : rd_ptr)};
        count_next = count;
        if (gnt_wr) begin
            count_next = count + 1'b1;
        end else if (gnt_rd) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            prio   <= PRIO_WR;
        end else begin
            prio  <= prio_next;
            count <= count_next;
            if (gnt_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (gnt_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // The memory read is combinational, so the out register captures mem_rdata on the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else if (gnt_rd) begin
            pop_valid <= 1'b1;
            pop_data  <= mem_rdata;
        end else if (pop_valid && pop_ready) begin
            pop_valid <= 1'b0;
        end
    end

`ifdef FIFO_PORT_CTRL_HWM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm <= '0;
        end else if (hwm_clr) begin
            hwm <= count;
        end else if (count_next > hwm) begin
            hwm <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_port_ctrl.sv
// Directed bench for fifo_port_ctrl with a behavioural register-file memory and an order scoreboard.
module tb_fifo_port_ctrl;
    import fifo_port_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              push_valid;
    logic              push_ready;
    logic [DW-1:0]     push_data;
    logic              pop_valid;
    logic              pop_ready;
    logic [DW-1:0]     pop_data;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_wen;
    logic              mem_ren;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
`ifdef FIFO_PORT_CTRL_HWM_EN
    logic              hwm_clr;
    logic [AW:0]       hwm;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram [16];
    logic [DW-1:0] sb [$];
    logic [AW-1:0] exp_wr;
    logic [AW-1:0] exp_rd;
    logic [MEM_AW-1:0] prev_waddr;
    int pushes;
    int pops;
    int wrap_count = 0;

    fifo_port_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef FIFO_PORT_CTRL_HWM_EN
        .hwm_clr    (hwm_clr),
        .hwm        (hwm),
`endif
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = '0;
    end

    // Register-file model: synchronous write, combinational read.
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Sampled 1 time unit before each rising edge: scoreboard, address sequence and wrap detection.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            sb.delete();
            exp_wr     = '0;
            exp_rd     = '0;
            prev_waddr = '0;
            pushes     = 0;
            pops       = 0;
        end else begin
            if (mem_wen) begin
                checkOutput("wr_addr", {28'd0, mem_addr}, {29'd0, exp_wr});
                checkOutput("wdata", {24'd0, mem_wdata}, {24'd0, push_data});
                if (prev_waddr == 4'd7 && mem_addr == 4'd0) wrap_count++;
                prev_waddr = mem_addr;
                exp_wr     = exp_wr + 1'b1;
            end
            if (mem_ren) begin
                checkOutput("rd_addr", {28'd0, mem_addr}, {29'd0, exp_rd});
                exp_rd = exp_rd + 1'b1;
            end
            if (push_valid && push_ready) begin
                sb.push_back(push_data);
                pushes++;
            end
            if (pop_valid && pop_ready) begin
                if (sb.size() == 0) checkOutput("pop_underflow", 1, 0);
                else checkOutput("pop_data", {24'd0, pop_data}, {24'd0, sb.pop_front()});
                pops++;
            end
        end
    end

    task automatic applyStimulus(input logic pv, input logic [DW-1:0] pd, input logic pr);
        @(negedge clk);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Holds push_valid until the DUT accepts the word at the following rising edge.
    task automatic push_word(input logic [DW-1:0] d, input logic pr);
        int n = 0;
        applyStimulus(1'b1, d, pr);
        #1;
        while (!push_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("push_accept", {31'd0, push_ready}, 1);
    endtask

    task automatic drain();
        int n = 0;
        applyStimulus(1'b0, 8'h00, 1'b1);
        #1;
        while ((pop_valid || !empty) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("drain_done", {30'd0, pop_valid, empty}, 32'h1);
        checkOutput("pop_total", pops, pushes);
    endtask

    initial begin
        int sent;
        int cyc;
        int w0;
        logic prev_wen;

        rst_n      = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;
`ifdef FIFO_PORT_CTRL_HWM_EN
        hwm_clr    = 1'b0;
`endif
        #1;
        checkOutput("reset_state", {23'd0, empty, full, count, pop_valid, mem_wen, mem_ren},
                    32'h100);
        checkOutput("reset_addr", {27'd0, mem_addr, push_ready}, 0);
        checkOutput("reset_pop_data", {24'd0, pop_data}, 0);
`ifdef FIFO_PORT_CTRL_HWM_EN
        checkOutput("reset_hwm", {28'd0, hwm}, 0);
`endif
        do_reset();

        // Idle: {empty,full,count,pop_valid,wen,ren} stays 1,0,0,0,0,0.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checkOutput("idle", {23'd0, empty, full, count, pop_valid, mem_wen, mem_ren}, 32'h100);
        end

        // Single transfer: write cycle 0, read cycle 1, data out cycle 2.
        applyStimulus(1'b1, 8'hA5, 1'b1);
        #1;
        checkOutput("st_c0_wen", {27'd0, mem_wen, mem_addr}, 32'h10);
        checkOutput("st_c0_ready", {31'd0, push_ready}, 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        #1;
        checkOutput("st_c1_ren", {26'd0, mem_ren, mem_wen, mem_addr}, 32'h20);
        checkOutput("st_c1_pop_valid", {31'd0, pop_valid}, 0);
        @(negedge clk);
        #1;
        checkOutput("st_c2_pop", {23'd0, pop_valid, pop_data}, 32'h1A5);
        checkOutput("st_c2_count", {28'd0, count}, 0);
        checkOutput("st_c2_ren", {31'd0, mem_ren}, 0);
        @(negedge clk);
        #1;
        checkOutput("st_c3_pop_valid", {31'd0, pop_valid}, 0);

        // Fill: 9 words with no consumer; 0x01 sits in the out register.
        do_reset();
        for (int i = 1; i <= 9; i++) push_word(8'(i), 1'b0);
        applyStimulus(1'b1, 8'h0A, 1'b0);
        #1;
        checkOutput("fill_count", {28'd0, count}, 8);
        checkOutput("fill_full", {30'd0, full, empty}, 32'h2);
        checkOutput("fill_push_ready", {31'd0, push_ready}, 0);
        checkOutput("fill_out_reg", {23'd0, pop_valid, pop_data}, 32'h101);
`ifdef FIFO_PORT_CTRL_HWM_EN
        checkOutput("fill_hwm", {28'd0, hwm}, 8);
`endif
        drain();
        checkOutput("fill_pops", pops, 9);

        // Contention: count=3, out register full, prio=WR at start.
        do_reset();
        for (int i = 0; i < 4; i++) push_word(8'(8'h80 + i), 1'b0);
        sent = 4;
        applyStimulus(1'b1, 8'(sent), 1'b1);
        #1;
        checkOutput("cont_count_start", {28'd0, count}, 3);
        checkOutput("cont_first_grant", {30'd0, mem_wen, mem_ren}, 32'h2);
        prev_wen = mem_wen;
        if (push_ready) sent++;
        cyc = 0;
        while (sent < 104 && cyc < 400) begin
            @(negedge clk);
            push_data = 8'(sent);
            #1;
            checkOutput("cont_one_grant", {31'd0, mem_wen ^ mem_ren}, 1);
            checkOutput("cont_alternate", {31'd0, mem_wen}, {31'd0, !prev_wen});
            checkOutput("cont_count_band", {31'd0, (count >= 4'd2 && count <= 4'd4)}, 1);
            prev_wen = mem_wen;
            if (push_ready) sent++;
            cyc++;
        end
        checkOutput("cont_words", sent, 104);
        drain();

        // Wrap-around: 20 words straight through.
        do_reset();
        w0 = wrap_count;
        for (int i = 0; i < 20; i++) push_word(8'(8'h40 + i), 1'b1);
        drain();
        checkOutput("addr_wrap", {31'd0, wrap_count > w0}, 1);
        checkOutput("wrap_pops", pops, 20);

        // Reset mid-stream with count=5 and the out register loaded.
        do_reset();
        for (int i = 0; i < 6; i++) push_word(8'(8'h60 + i), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        #1;
        checkOutput("mid_count", {28'd0, count}, 5);
        checkOutput("mid_pop_valid", {31'd0, pop_valid}, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_state", {23'd0, empty, full, count, pop_valid, mem_wen, mem_ren},
                    32'h100);
        checkOutput("mid_rst_addr", {28'd0, mem_addr}, 0);
        @(negedge clk);
        #1;
        checkOutput("mid_rst_hold", {15'd0, count, pop_valid, pop_data, mem_addr}, 0);
`ifdef FIFO_PORT_CTRL_HWM_EN
        checkOutput("mid_rst_hwm", {28'd0, hwm}, 0);
`endif
        rst_n = 1'b1;
        push_word(8'h77, 1'b1);
        drain();
        checkOutput("post_rst_pops", pops, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fifo_port_ctrl.md
Name: fifo_port_ctrl

Overview:
- Ready/valid FIFO controller that sits directly upstream of the team's 8x8 single-port register-file memory.
- Converts a push stream and a pop stream into the memory's shared addr/wen/ren port, keeping circular read and write pointers and an occupancy count.
- Adds a one-entry output register so pop data is always registered.
- Arbitrates push and pop, because the memory accepts only one access per cycle.

Parameters:
- DW, 8, data width; must equal the memory word width.
- DEPTH, 8, number of memory entries; power of two.
- AW, 3, pointer width, log2(DEPTH).
- MEM_AW, 4, memory address port width; bits above AW are driven 0.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- push_valid  input  1  producer has data
- push_ready  output  1  write accepted this cycle
- push_data  input  DW  producer data
- pop_valid  output  1  out register holds data
- pop_ready  input  1  consumer takes data
- pop_data  output  DW  registered output data
- mem_addr  output  MEM_AW  memory address
- mem_wen  output  1  memory write enable
- mem_ren  output  1  memory read enable
- mem_wdata  output  DW  memory write data, equal to push_data
- mem_rdata  input  DW  memory read data, valid in the same cycle as mem_ren
- count  output  AW+1  entries held in memory, excluding the out register
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Reset values: wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, pop_data=0, prio=WR. Outputs are therefore push_ready=0, mem_wen=0, mem_ren=0, mem_addr=0, full=0, empty=1.
- Reset mid-operation discards all in-flight state. Memory contents are not cleared by this block.
- want_wr = push_valid && !full.
- want_rd = !empty && (!pop_valid || pop_ready). A refill may occur in the same cycle as a pop.
- Arbiter state is prio ∈ {WR, RD}. Only one grant per cycle.
  - Only one request: grant it.
  - Both request: grant prio, then toggle prio to the other side.
  - Without contention prio is unchanged.
- Write grant (combinational):
  - push_ready=1, mem_wen=1, mem_addr=wr_ptr.
  - At the edge: wr_ptr += 1 mod DEPTH.
- Read grant (combinational):
  - mem_ren=1, mem_addr=rd_ptr.
  - At the edge: pop_data <= mem_rdata, pop_valid <= 1, rd_ptr += 1 mod DEPTH.
- Read latency: data written at edge E is visible on pop_data no earlier than edge E+1 after a read grant. Minimum push-to-pop_valid is 2 cycles.
- Pop only (no read grant): pop_valid && pop_ready clears pop_valid at the edge.
- count: +1 on a write grant, -1 on a read grant, never both. No wrap past 0 or DEPTH.
- Pointer wrap: 7→0 at DEPTH=8.
- Full: push_ready=0 until a read grant frees an entry. No overflow is possible.
- Empty with pop_valid=0: no read is issued; pop_valid stays 0.
- Total buffering is DEPTH+1 entries: memory plus out register.
- With no grant: mem_wen=mem_ren=0 and mem_addr holds rd_ptr.

Optional Feature:
- FIFO_PORT_CTRL_HWM_EN
- Defined: adds output hwm[AW:0] (reset 0), updated at each edge to max(hwm, next count). Adds input hwm_clr, which synchronously resets hwm to the current count.
- Undefined: hwm_clr and hwm ports are absent; no extra logic.

Decomposition:
- Package fifo_port_pkg holds:
  - localparams DW=8, DEPTH=8, AW=3, MEM_AW=4;
  - typedef enum logic {PRIO_WR, PRIO_RD} prio_t;
  - typedefs data_t and ptr_t.
- One natural sub-module: fifo_port_arb. It takes want_wr, want_rd and prio and returns gnt_wr, gnt_rd and next prio, so it can be verified standalone.
- The pointer, count and output-register logic stays in the top module.

Test Plan:
- Reset, idle: release rst_n with no traffic → empty=1, full=0, count=0, pop_valid=0, mem_wen=mem_ren=0 for 10 cycles.
- Single transfer: push 0xA5 at cycle 0 with pop_ready=1 → mem_wen at cycle 0 with addr 0; mem_ren at cycle 1 with addr 0; pop_valid=1 and pop_data=0xA5 at cycle 2. Then count=0.
- Fill: push 0x01..0x09 with pop_ready=0. 0x01 moves to the out register, 0x02..0x09 fill memory → count=8, full=1, push_ready=0 on the next attempt. Draining returns 0x01..0x09 in order.
- Contention: continuous push and pop_ready=1 with FIFO half full → grants alternate WR, RD, WR, RD; count stable ±1; no data loss or reorder over 100 words.
- Wrap-around: 20 words streamed through → mem_addr wraps 7→0; the output sequence matches the input sequence.
- Reset mid-stream: assert rst_n low while count=5 and pop_valid=1 → next cycle count=0, pop_valid=0, ptrs=0. With HWM_EN defined, hwm=0 after reset and hwm=8 after the fill scenario.
